// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 7x16 register file write port.
// Chooses between the execute unit (EXE) and the load/memory unit (MEM).
// MEM normally wins, but EXE gets forced priority after MAX_WAIT denials.
// Also keeps a load scoreboard and produces the issue-stage read hazard.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 3,
  parameter int DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          exe_valid,
  input  logic [2:0]    exe_rd,
  input  logic [DW-1:0] exe_data,
  output logic          exe_ready,
  input  logic          mem_valid,
  input  logic [2:0]    mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          ld_issue_valid,
  input  logic [2:0]    ld_issue_rd,
  output logic          ld_issue_ready,
  input  logic [2:0]    hz_rs1,
  input  logic [2:0]    hz_rs2,
  output logic          hazard,
  output logic [6:0]    busy,
  output logic [2:0]    rf_rd,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_en
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // One-hot scoreboard mask for a register; r0 has no scoreboard bit.
  function automatic logic [6:0] reg_mask(input logic [2:0] r);
    logic [6:0] m;
    if (r == 3'd0) begin
      m = 7'd0;
    end else begin
      m = 7'd1 << (r - 3'd1);
    end
    return m;
  endfunction

  logic [3:0]    cnt_r;
  logic [6:0]    busy_r;
  logic          rf_en_r;
  logic [2:0]    rf_rd_r;
  logic [DW-1:0] rf_wdata_r;
  logic          src_mem_r;

  logic          exe_win_s;
  logic          mem_win_s;
  logic          ld_ready_s;
  logic [6:0]    wr_mask_s;
  logic [6:0]    clr_mask_s;
  logic [6:0]    set_mask_s;
  logic [6:0]    busy_nxt_s;
  logic [3:0]    cnt_nxt_s;

  // Arbitration: MEM wins contention unless EXE has waited MAX_WAIT cycles.
  always_comb begin
    exe_win_s = 1'b0;
    mem_win_s = 1'b0;
    if (exe_valid && (!mem_valid || (cnt_r == MAX_WAIT_C))) begin
      exe_win_s = 1'b1;
    end else begin
      exe_win_s = 1'b0;
    end
    if (mem_valid && !exe_win_s) begin
      mem_win_s = 1'b1;
    end else begin
      mem_win_s = 1'b0;
    end
  end

  // Starvation counter next value: count denied EXE cycles, saturating.
  always_comb begin
    cnt_nxt_s = 4'd0;
    if (exe_valid && !exe_win_s) begin
      if (cnt_r == MAX_WAIT_C) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + 4'd1;
      end
    end else begin
      cnt_nxt_s = 4'd0;
    end
  end

  // Scoreboard update and hazard: a MEM write landing clears, an accepted load issue sets (set wins).
  always_comb begin
    wr_mask_s  = 7'd0;
    clr_mask_s = 7'd0;
    set_mask_s = 7'd0;
    ld_ready_s = ~|(reg_mask(ld_issue_rd) & busy_r);
    if (rf_en_r) begin
      wr_mask_s = reg_mask(rf_rd_r);
    end else begin
      wr_mask_s = 7'd0;
    end
    if (rf_en_r && src_mem_r) begin
      clr_mask_s = reg_mask(rf_rd_r);
    end else begin
      clr_mask_s = 7'd0;
    end
    if (ld_issue_valid && ld_ready_s) begin
      set_mask_s = reg_mask(ld_issue_rd);
    end else begin
      set_mask_s = 7'd0;
    end
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Starvation counter and scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= 4'd0;
      busy_r <= 7'd0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= busy_nxt_s;
    end
  end

  // Registered write port: capture the accepted request; rd=0 completes without enabling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_en_r    <= 1'b0;
      rf_rd_r    <= 3'd0;
      rf_wdata_r <= '0;
      src_mem_r  <= 1'b0;
    end else if (exe_win_s) begin
      rf_en_r    <= (exe_rd != 3'd0);
      rf_rd_r    <= exe_rd;
      rf_wdata_r <= exe_data;
      src_mem_r  <= 1'b0;
    end else if (mem_win_s) begin
      rf_en_r    <= (mem_rd != 3'd0);
      rf_rd_r    <= mem_rd;
      rf_wdata_r <= mem_data;
      src_mem_r  <= 1'b1;
    end else begin
      rf_en_r    <= 1'b0;
      rf_rd_r    <= rf_rd_r;
      rf_wdata_r <= rf_wdata_r;
      src_mem_r  <= src_mem_r;
    end
  end

  assign exe_ready      = exe_win_s;
  assign mem_ready      = mem_win_s;
  assign ld_issue_ready = ld_ready_s;
  assign hazard         = |((reg_mask(hz_rs1) | reg_mask(hz_rs2)) & (busy_r | wr_mask_s));
  assign busy           = busy_r;
  assign rf_en          = rf_en_r;
  assign rf_rd          = rf_rd_r;
  assign rf_wdata       = rf_wdata_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, reset-mid-write
// sequence, and randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int MAX_WAIT = 3;
  localparam int DW       = 16;

  logic          clk;
  logic          reset;
  logic          exe_valid;
  logic [2:0]    exe_rd;
  logic [DW-1:0] exe_data;
  logic          exe_ready;
  logic          mem_valid;
  logic [2:0]    mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          ld_issue_valid;
  logic [2:0]    ld_issue_rd;
  logic          ld_issue_ready;
  logic [2:0]    hz_rs1;
  logic [2:0]    hz_rs2;
  logic          hazard;
  logic [6:0]    busy;
  logic [2:0]    rf_rd;
  logic [DW-1:0] rf_wdata;
  logic          rf_en;

  int errors = 0;
  int checks = 0;

  rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_rd(exe_rd), .exe_data(exe_data), .exe_ready(exe_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hazard(hazard), .busy(busy),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_en(rf_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ev; logic [2:0] erd; logic [15:0] ed;
    logic mv; logic [2:0] mrd; logic [15:0] md;
    logic lv; logic [2:0] lrd; logic [2:0] rs1; logic [2:0] rs2;
    logic x_erdy; logic x_mrdy; logic x_lrdy; logic x_hz; logic x_en;
    logic [2:0] x_rd; logic [15:0] x_wd; logic [6:0] x_busy;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic erdy, input logic mrdy, input logic lrdy,
                           input logic hz, input logic en, input logic [2:0] rd,
                           input logic [15:0] wd, input logic [6:0] bz);
    chk("exe_ready", idx, 32'(exe_ready), 32'(erdy));
    chk("mem_ready", idx, 32'(mem_ready), 32'(mrdy));
    chk("ld_issue_ready", idx, 32'(ld_issue_ready), 32'(lrdy));
    chk("hazard", idx, 32'(hazard), 32'(hz));
    chk("rf_en", idx, 32'(rf_en), 32'(en));
    chk("rf_rd", idx, 32'(rf_rd), 32'(rd));
    chk("rf_wdata", idx, 32'(rf_wdata), 32'(wd));
    chk("busy", idx, 32'(busy), 32'(bz));
  endtask

  task automatic idle_inputs();
    exe_valid = 1'b0; exe_rd = 3'd0; exe_data = 16'h0000;
    mem_valid = 1'b0; mem_rd = 3'd0; mem_data = 16'h0000;
    ld_issue_valid = 1'b0; ld_issue_rd = 3'd0; hz_rs1 = 3'd0; hz_rs2 = 3'd0;
  endtask

  // Behavioural model state for the random phase.
  int          m_starve;
  bit          m_en;
  int          m_rd;
  logic [15:0] m_wd;
  bit          m_from_mem;
  bit          m_busy[8];

  initial begin
    // Fields: ev erd ed | mv mrd md | lv lrd rs1 rs2 || erdy mrdy lrdy hz en rd wd busy
    // Single EXE write to r5
    vt[0]  = '{1'b1,3'd5,16'hBEEF, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,3'd0,16'h0000,7'b0000000};
    vt[1]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,3'd5,16'hBEEF,7'b0000000};
    vt[2]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd5,16'hBEEF,7'b0000000};
    // Contention: MEM x3, EXE forced, MEM again
    vt[3]  = '{1'b1,3'd2,16'h2222, 1'b1,3'd1,16'h1111, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,3'd5,16'hBEEF,7'b0000000};
    vt[4]  = '{1'b1,3'd2,16'h2222, 1'b1,3'd1,16'h1111, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd1,16'h1111,7'b0000000};
    vt[5]  = '{1'b1,3'd2,16'h2222, 1'b1,3'd1,16'h1111, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd1,16'h1111,7'b0000000};
    vt[6]  = '{1'b1,3'd2,16'h2222, 1'b1,3'd1,16'h1111, 1'b0,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b1,1'b0,1'b1,3'd1,16'h1111,7'b0000000};
    vt[7]  = '{1'b1,3'd2,16'h2222, 1'b1,3'd1,16'h1111, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b1,1'b0,1'b1,3'd2,16'h2222,7'b0000000};
    vt[8]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b1,3'd1,16'h1111,7'b0000000};
    vt[9]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd1,16'h1111,7'b0000000};
    // Scoreboard on r4
    vt[10] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd4,3'd4,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd1,16'h1111,7'b0000000};
    vt[11] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd4,3'd4,3'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,3'd1,16'h1111,7'b0001000};
    vt[12] = '{1'b0,3'd0,16'h0000, 1'b1,3'd4,16'h00AA, 1'b0,3'd0,3'd4,3'd0, 1'b0,1'b1,1'b1,1'b1,1'b0,3'd1,16'h1111,7'b0001000};
    vt[13] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd4,3'd0, 1'b0,1'b0,1'b1,1'b1,1'b1,3'd4,16'h00AA,7'b0001000};
    vt[14] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd4,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd4,16'h00AA,7'b0000000};
    // Set/clear collision on r6
    vt[15] = '{1'b0,3'd0,16'h0000, 1'b1,3'd6,16'h6666, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,3'd4,16'h00AA,7'b0000000};
    vt[16] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd6,3'd0,3'd6, 1'b0,1'b0,1'b1,1'b1,1'b1,3'd6,16'h6666,7'b0000000};
    vt[17] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd6, 1'b0,1'b0,1'b1,1'b1,1'b0,3'd6,16'h6666,7'b0100000};
    // r0 handling
    vt[18] = '{1'b1,3'd0,16'h0F0F, 1'b0,3'd0,16'h0000, 1'b1,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b1,1'b0,1'b0,3'd6,16'h6666,7'b0100000};
    vt[19] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,16'h0F0F,7'b0100000};
    vt[20] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0,1'b0,3'd0,16'h0F0F,7'b0100000};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rf_en", 0, 32'(rf_en), 32'd0);
    chk("reset_rf_rd", 0, 32'(rf_rd), 32'd0);
    chk("reset_rf_wdata", 0, 32'(rf_wdata), 32'd0);
    chk("reset_busy", 0, 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      exe_valid = vt[i].ev; exe_rd = vt[i].erd; exe_data = vt[i].ed;
      mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
      ld_issue_valid = vt[i].lv; ld_issue_rd = vt[i].lrd;
      hz_rs1 = vt[i].rs1; hz_rs2 = vt[i].rs2;
      #1;
      check_all(i, vt[i].x_erdy, vt[i].x_mrdy, vt[i].x_lrdy, vt[i].x_hz,
                vt[i].x_en, vt[i].x_rd, vt[i].x_wd, vt[i].x_busy);
    end

    // Reset asserted across the accept edge drops the write
    @(negedge clk);
    exe_valid = 1'b1; exe_rd = 3'd3; exe_data = 16'h1234;
    ld_issue_valid = 1'b1; ld_issue_rd = 3'd2;
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_rf_en", 0, 32'(rf_en), 32'd0);
    chk("midrst_busy", 0, 32'(busy), 32'd0);
    chk("midrst_rf_rd", 0, 32'(rf_rd), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("postrst_rf_en", 0, 32'(rf_en), 32'd0);
    chk("postrst_busy", 0, 32'(busy), 32'd0);
    chk("postrst_rf_wdata", 0, 32'(rf_wdata), 32'd0);

    // Randomized traffic against the behavioural model (state is post-reset)
    m_starve = 0; m_en = 1'b0; m_rd = 0; m_wd = 16'h0000; m_from_mem = 1'b0;
    for (int r = 0; r < 8; r++) m_busy[r] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bit          x_exe, x_mem, x_ld, x_hz;
      logic [6:0]  x_busy;
      @(negedge clk);
      exe_valid = ($urandom_range(0, 99) < 60);
      exe_rd = 3'($urandom_range(0, 7)); exe_data = 16'($urandom);
      mem_valid = ($urandom_range(0, 99) < 50);
      mem_rd = 3'($urandom_range(0, 7)); mem_data = 16'($urandom);
      ld_issue_valid = ($urandom_range(0, 99) < 35);
      ld_issue_rd = 3'($urandom_range(0, 7));
      hz_rs1 = 3'($urandom_range(0, 7)); hz_rs2 = 3'($urandom_range(0, 7));
      #1;
      x_exe = exe_valid && (!mem_valid || m_starve == MAX_WAIT);
      x_mem = mem_valid && !x_exe;
      x_ld  = (ld_issue_rd == 3'd0) || !m_busy[ld_issue_rd];
      x_hz  = 1'b0;
      if (hz_rs1 != 3'd0 && (m_busy[hz_rs1] || (m_en && m_rd == int'(hz_rs1)))) x_hz = 1'b1;
      if (hz_rs2 != 3'd0 && (m_busy[hz_rs2] || (m_en && m_rd == int'(hz_rs2)))) x_hz = 1'b1;
      for (int r = 1; r < 8; r++) x_busy[r-1] = m_busy[r];
      check_all(1000 + c, x_exe, x_mem, x_ld, x_hz, m_en, 3'(m_rd), m_wd, x_busy);
      // Advance the model to the next edge
      if (exe_valid && !x_exe) m_starve = (m_starve < MAX_WAIT) ? m_starve + 1 : MAX_WAIT;
      else m_starve = 0;
      if (m_en && m_from_mem) m_busy[m_rd] = 1'b0;
      if (ld_issue_valid && x_ld && ld_issue_rd != 3'd0) m_busy[ld_issue_rd] = 1'b1;
      if (x_exe) begin
        m_en = (exe_rd != 3'd0); m_rd = int'(exe_rd); m_wd = exe_data; m_from_mem = 1'b0;
      end else if (x_mem) begin
        m_en = (mem_rd != 3'd0); m_rd = int'(mem_rd); m_wd = mem_data; m_from_mem = 1'b1;
      end else begin
        m_en = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 7x16 register file (r0 hardwired zero, writes ignored).
- Arbitrates between two writeback sources, the execute unit (EXE) and the load/memory unit (MEM), and drives the port's Rd / write_data / EN.
- Keeps a load scoreboard of registers with outstanding loads and gives the issue stage a read-hazard signal.
- Sits between the execute/memory stages and the register file.

Parameters:
- MAX_WAIT, 3, consecutive cycles EXE may be denied while valid before it gets forced priority (1..15)
- DW, 16, data width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- exe_valid  in  1  EXE write request
- exe_rd  in  3  EXE destination
- exe_data  in  DW  EXE write data
- exe_ready  out  1  EXE request accepted this cycle
- mem_valid  in  1  MEM load-return request
- mem_rd  in  3  MEM destination
- mem_data  in  DW  MEM write data
- mem_ready  out  1  MEM request accepted this cycle
- ld_issue_valid  in  1  load issued, marks destination busy
- ld_issue_rd  in  3  load destination
- ld_issue_ready  out  1  load may issue
- hz_rs1  in  3  issue-stage source 1
- hz_rs2  in  3  issue-stage source 2
- hazard  out  1  a source is not yet readable from the register file
- busy  out  7  scoreboard bits for r1..r7 (bit 0 = r1)
- rf_rd  out  3  to register file Rd
- rf_wdata  out  DW  to register file write_data
- rf_en  out  1  to register file EN

Behaviour:
- Reset (async, active-high):
  - rf_en=0, rf_rd=0, rf_wdata=0, busy=0, starvation counter=0.
  - Any in-flight output write is dropped; mid-operation reset drops it identically.
- Accept rule: accept = valid & ready. At most one source is accepted per cycle. exe_ready and mem_ready are combinational from valids and counter state and never both high.
- Arbitration:
  - Only one valid: it is accepted.
  - Both valid: MEM wins, unless counter == MAX_WAIT, then EXE wins.
- Starvation counter:
  - Increments each cycle exe_valid=1 and EXE is not accepted; saturates at MAX_WAIT.
  - Clears on EXE accept or when exe_valid=0.
- Output stage (1-cycle latency, registered):
  - Cycle after an accept: rf_rd and rf_wdata hold the accepted rd/data, and rf_en=1 if rd!=0.
  - Accepted rd=0: handshake completes, rf_en stays 0.
  - No accept: rf_en=0; rf_rd and rf_wdata hold their previous values.
- Scoreboard:
  - Set: ld_issue_valid & ld_issue_ready & ld_issue_rd!=0 sets busy[ld_issue_rd] at the next edge.
  - ld_issue_ready = 0 when ld_issue_rd!=0 and busy[ld_issue_rd]=1, i.e. one outstanding load per register.
  - Clear: busy[r] clears at the edge ending the cycle in which rf_en=1, rf_rd=r, and that write came from MEM. A one-bit source tag is carried in the output stage. EXE writes never clear busy.
  - Set and clear of the same r on the same edge: set wins.
- hazard:
  - For each nonzero source s in {hz_rs1, hz_rs2}, hazard=1 if busy[s]=1.
  - Also hazard=1 if rf_en=1 and rf_rd=s (write lands this edge, so the read returns stale data).
  - Sources equal to 0 never hazard.
- EXE write to a busy register: allowed and written. It does not clear busy, so the later MEM return overwrites it. Program order is the issue stage's responsibility.
- Held requests: a valid request with ready=0 must be held stable by the source. The arbiter samples only on the accept cycle.

Test Plan:
- Reset mid-write: exe_valid=1, exe_rd=3, exe_data=16'h1234; assert reset on the accept edge -> rf_en=0, busy=0 immediately; after release no write occurs.
- Single source: exe_valid=1, exe_rd=5, exe_data=16'hBEEF for one cycle -> exe_ready=1 the same cycle; next cycle rf_en=1, rf_rd=5, rf_wdata=16'hBEEF; following cycle rf_en=0.
- Contention/starvation (MAX_WAIT=3):
  - Stimulus: mem_valid and exe_valid held high, rds 1 and 2.
  - MEM accepted for cycles 0-2, EXE accepted at cycle 3, counter back to 0, MEM accepted again at cycle 4.
- Scoreboard (r4):
  - Issue load to r4 -> busy[3]=1 and hazard=1 for hz_rs1=4.
  - Second issue to r4 -> ld_issue_ready=0.
  - mem write r4=16'h00AA accepted -> rf_en cycle shows hazard=1; busy[3]=0 and hazard=0 the cycle after.
- Set/clear collision: MEM return to r6 in its rf_en cycle coincides with a new accepted issue to r6 -> busy[5] remains 1.
- r0 handling: exe_rd=0 accepted -> no rf_en pulse. ld_issue_rd=0 -> busy unchanged, ld_issue_ready=1. hz_rs1=hz_rs2=0 -> hazard=0.
